// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter for four byte requesters feeding one
// UART transmit line. One frame = START, DATA_BITS data bits (LSB first),
// optional even parity bit, STOP_BITS stop bits; each bit is OVERSAMPLE
// sample_tick pulses long.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after DATA).
module uart_tx_scheduler #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [3:0]             req,
  input  logic [4*DATA_BITS-1:0] data,
  output logic [3:0]             ack,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   done,
  output logic                   tx
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = 4;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             rr_q, rr_d;
  logic [3:0]             ack_q, ack_d;
  logic [1:0]             grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   bit_end;
  logic                   pick_found;
  logic [1:0]             pick_id;
  logic [1:0]             cand;
  logic [DATA_BITS-1:0]   lane [4];

  // Split the packed data bus into per-requester bytes.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = data[i*DATA_BITS +: DATA_BITS];
  end

  // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = 2'd0;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state, bit timing and registered-output computation.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rr_d     = rr_q;
    ack_d    = 4'b0000;
    grant_d  = grant_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_end  = sample_tick && (tick_q == TICK_LAST);

    // Ticks only count once a bit is in progress; each bit end restarts the count.
    if (state_q != IDLE && sample_tick) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = START;
          shift_d  = lane[pick_id];
          ack_d    = 4'b0001 << pick_id;
          grant_d  = pick_id;
          rr_d     = pick_id + 2'd1;
          tick_d   = '0;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^lane[pick_id];
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rr_q     <= 2'd0;
      ack_q    <= 4'b0000;
      grant_q  <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rr_q     <= rr_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx       = tx_q;

endmodule
